// File: rtl/pkg_drop_walker.sv
// pkg_drop_walker: drop/release walker between the per-port packet-read front
// ends and the address-recycle path.
//
// Four ports post (first address, block count - 1) requests. One is granted
// round-robin, and its linked list is walked through the link-list SRAM drop-read
// port. Every block address goes to the recycle input in chain order. Only one
// packet is handled at a time.
//
// Optional build macro: PKG_DROP_TIMEOUT_EN
//   defined   : WAIT is bounded by a 6-bit counter; after 63 cycles with no SRAM
//               return, oTimeoutErr pulses, the packet is abandoned and the FSM
//               goes back to IDLE.
//   undefined : WAIT waits indefinitely and oTimeoutErr is tied to 0.

module pkg_drop_walker #(
  parameter int ADDR_LENTH = 12,
  parameter int NUM_WIDTH  = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,

  // Port 0 request
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr0,
  input  logic                  iPkgFirAddrVld0,
  input  logic [NUM_WIDTH-1:0]  iPkgBlockNum0,
  output logic                  oPkgFirAddrRdy0,

  // Port 1 request
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr1,
  input  logic                  iPkgFirAddrVld1,
  input  logic [NUM_WIDTH-1:0]  iPkgBlockNum1,
  output logic                  oPkgFirAddrRdy1,

  // Port 2 request
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr2,
  input  logic                  iPkgFirAddrVld2,
  input  logic [NUM_WIDTH-1:0]  iPkgBlockNum2,
  output logic                  oPkgFirAddrRdy2,

  // Port 3 request
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr3,
  input  logic                  iPkgFirAddrVld3,
  input  logic [NUM_WIDTH-1:0]  iPkgBlockNum3,
  output logic                  oPkgFirAddrRdy3,

  // Link-list SRAM drop-read port
  output logic [ADDR_LENTH-1:0] oLinkAddr,
  output logic                  oLinkAddrVld,
  input  logic [ADDR_LENTH-1:0] iLinkData,
  input  logic                  iLinkDataVld,

  // Recycle output to the free-address controller
  output logic [ADDR_LENTH-1:0] oRecAddr,
  output logic                  oRecAddrVld,
  input  logic                  iRecAddrRdy,

  // Status
  output logic                  oBusy,
  output logic                  oTimeoutErr
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEmit = 2'd1,
    StRead = 2'd2,
    StWait = 2'd3
  } stateE;

  stateE                 rState;
  logic [1:0]            rRrPtr;
  logic [ADDR_LENTH-1:0] rCurAddr;
  logic [NUM_WIDTH-1:0]  rRemain;

`ifdef PKG_DROP_TIMEOUT_EN
  localparam logic [5:0] TimeoutLast = 6'd62;
  logic [5:0]            rTimeCnt;
`endif

  // Request bundles gathered into arrays so the arbiter can index them
  logic [ADDR_LENTH-1:0] reqAddr [4];
  logic [NUM_WIDTH-1:0]  reqNum  [4];
  logic [3:0]            reqVld;

  assign reqAddr[0] = iPkgFirAddr0;
  assign reqAddr[1] = iPkgFirAddr1;
  assign reqAddr[2] = iPkgFirAddr2;
  assign reqAddr[3] = iPkgFirAddr3;

  assign reqNum[0]  = iPkgBlockNum0;
  assign reqNum[1]  = iPkgBlockNum1;
  assign reqNum[2]  = iPkgBlockNum2;
  assign reqNum[3]  = iPkgBlockNum3;

  assign reqVld     = {iPkgFirAddrVld3, iPkgFirAddrVld2, iPkgFirAddrVld1, iPkgFirAddrVld0};

  logic       grantFound;
  logic [1:0] grantIdx;
  logic [3:0] grantVec;

  // Round-robin search starting just after the last granted port
  always_comb begin
    logic [1:0] cand;
    grantFound = 1'b0;
    grantIdx   = rRrPtr;
    cand       = rRrPtr;
    for (int i = 1; i <= 4; i++) begin
      cand = rRrPtr + 2'(i);
      if (!grantFound && reqVld[cand]) begin
        grantFound = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  // Ready is combinational and only ever offered while idle
  always_comb begin
    grantVec = 4'b0000;
    if (rState == StIdle && grantFound) begin
      grantVec = 4'b0001 << grantIdx;
    end
  end

  assign oPkgFirAddrRdy0 = grantVec[0];
  assign oPkgFirAddrRdy1 = grantVec[1];
  assign oPkgFirAddrRdy2 = grantVec[2];
  assign oPkgFirAddrRdy3 = grantVec[3];

`ifndef PKG_DROP_TIMEOUT_EN
  assign oTimeoutErr = 1'b0;
`endif

  // Walker FSM with registered outputs; reset abandons any packet in flight
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rState       <= StIdle;
      rRrPtr       <= 2'd3;
      rCurAddr     <= '0;
      rRemain      <= '0;
      oRecAddr     <= '0;
      oRecAddrVld  <= 1'b0;
      oLinkAddr    <= '0;
      oLinkAddrVld <= 1'b0;
      oBusy        <= 1'b0;
`ifdef PKG_DROP_TIMEOUT_EN
      rTimeCnt     <= '0;
      oTimeoutErr  <= 1'b0;
`endif
    end else begin
`ifdef PKG_DROP_TIMEOUT_EN
      oTimeoutErr <= 1'b0;
`endif
      case (rState)
        StIdle: begin
          if (grantFound) begin
            rCurAddr    <= reqAddr[grantIdx];
            rRemain     <= reqNum[grantIdx];
            rRrPtr      <= grantIdx;
            oRecAddr    <= reqAddr[grantIdx];
            oRecAddrVld <= 1'b1;
            oBusy       <= 1'b1;
            rState      <= StEmit;
          end
        end

        StEmit: begin
          if (iRecAddrRdy) begin
            oRecAddrVld <= 1'b0;
            if (rRemain == '0) begin
              oBusy  <= 1'b0;
              rState <= StIdle;
            end else begin
              oLinkAddr    <= rCurAddr;
              oLinkAddrVld <= 1'b1;
              rState       <= StRead;
            end
          end
        end

        StRead: begin
          // The strobe was raised on entry; drop it so it lasts one cycle
          oLinkAddrVld <= 1'b0;
`ifdef PKG_DROP_TIMEOUT_EN
          rTimeCnt     <= '0;
`endif
          rState       <= StWait;
        end

        StWait: begin
          if (iLinkDataVld) begin
            // rRemain is non-zero here: READ is only entered when blocks remain
            rCurAddr    <= iLinkData;
            rRemain     <= rRemain - 1'b1;
            oRecAddr    <= iLinkData;
            oRecAddrVld <= 1'b1;
            rState      <= StEmit;
          end
`ifdef PKG_DROP_TIMEOUT_EN
          else if (rTimeCnt == TimeoutLast) begin
            // 63rd silent WAIT cycle: give up on this packet
            oTimeoutErr <= 1'b1;
            oBusy       <= 1'b0;
            rState      <= StIdle;
          end else begin
            rTimeCnt <= rTimeCnt + 6'd1;
          end
`endif
        end

        default: begin
          oRecAddrVld  <= 1'b0;
          oLinkAddrVld <= 1'b0;
          oBusy        <= 1'b0;
          rState       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkg_drop_walker.sv
// Directed bench for pkg_drop_walker: single block, chain walk, round-robin
// arbitration, recycle backpressure, reset mid-walk and (when built with
// PKG_DROP_TIMEOUT_EN) the WAIT timeout.

module tb_pkg_drop_walker;

  localparam int AW = 12;
  localparam int NW = 4;

  logic          iClk;
  logic          iRst_n;
  logic [AW-1:0] pkgAddr [4];
  logic          pkgVld  [4];
  logic [NW-1:0] pkgNum  [4];
  wire  [3:0]    pkgRdy;
  wire  [AW-1:0] oLinkAddr;
  wire           oLinkAddrVld;
  logic [AW-1:0] iLinkData;
  logic          iLinkDataVld;
  wire  [AW-1:0] oRecAddr;
  wire           oRecAddrVld;
  logic          iRecAddrRdy;
  wire           oBusy;
  wire           oTimeoutErr;

  pkg_drop_walker #(
    .ADDR_LENTH (AW),
    .NUM_WIDTH  (NW)
  ) dut (
    .iClk            (iClk),
    .iRst_n          (iRst_n),
    .iPkgFirAddr0    (pkgAddr[0]),
    .iPkgFirAddrVld0 (pkgVld[0]),
    .iPkgBlockNum0   (pkgNum[0]),
    .oPkgFirAddrRdy0 (pkgRdy[0]),
    .iPkgFirAddr1    (pkgAddr[1]),
    .iPkgFirAddrVld1 (pkgVld[1]),
    .iPkgBlockNum1   (pkgNum[1]),
    .oPkgFirAddrRdy1 (pkgRdy[1]),
    .iPkgFirAddr2    (pkgAddr[2]),
    .iPkgFirAddrVld2 (pkgVld[2]),
    .iPkgBlockNum2   (pkgNum[2]),
    .oPkgFirAddrRdy2 (pkgRdy[2]),
    .iPkgFirAddr3    (pkgAddr[3]),
    .iPkgFirAddrVld3 (pkgVld[3]),
    .iPkgBlockNum3   (pkgNum[3]),
    .oPkgFirAddrRdy3 (pkgRdy[3]),
    .oLinkAddr       (oLinkAddr),
    .oLinkAddrVld    (oLinkAddrVld),
    .iLinkData       (iLinkData),
    .iLinkDataVld    (iLinkDataVld),
    .oRecAddr        (oRecAddr),
    .oRecAddrVld     (oRecAddrVld),
    .iRecAddrRdy     (iRecAddrRdy),
    .oBusy           (oBusy),
    .oTimeoutErr     (oTimeoutErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkVal(input string tag, input int obs, input int exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Link-list SRAM model with one-cycle read latency
  logic [AW-1:0] linkMem [4096];
  logic          sramEn;

  always @(posedge iClk) begin
    iLinkDataVld <= oLinkAddrVld && sramEn;
    iLinkData    <= linkMem[oLinkAddr];
  end

  // Record recycle handshakes and SRAM reads
  int recQ[$];
  int rdQ[$];

  always @(posedge iClk) begin
    if (iRst_n && oRecAddrVld && iRecAddrRdy) recQ.push_back(int'(oRecAddr));
    if (iRst_n && oLinkAddrVld) rdQ.push_back(int'(oLinkAddr));
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic doReset();
    iRst_n = 1'b0;
    tick();
    tick();
    iRst_n = 1'b1;
    tick();
  endtask

  // Raise a request, wait (bounded) for its ready, let it be accepted, drop it
  task automatic request(input int p, input int addr, input int num);
    int n;
    pkgAddr[p] = AW'(addr);
    pkgNum[p]  = NW'(num);
    pkgVld[p]  = 1'b1;
    #1;
    n = 0;
    while (!pkgRdy[p] && n < 50) begin
      tick();
      n++;
    end
    checkVal($sformatf("rdy_port%0d", p), int'(pkgRdy[p]), 1);
    tick();
    pkgVld[p] = 1'b0;
  endtask

  // Count busy cycles until the walker returns to IDLE
  task automatic waitIdle(output int busyCycles);
    int n;
    n = 0;
    while (oBusy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) checkVal("idle_bound", 0, 1);
    busyCycles = n;
  endtask

  // Track grants while several ports hold their valids
  int grantQ[$];

  task automatic grantLoop(input int want);
    int n;
    int gp;
    n = 0;
    #1;
    while (grantQ.size() < want && n < 40) begin
      gp = -1;
      for (int p = 0; p < 4; p++) begin
        if (pkgRdy[p]) begin
          grantQ.push_back(p);
          gp = p;
        end
      end
      tick();
      if (gp >= 0) pkgVld[gp] = 1'b0;
      #1;
      n++;
    end
    if (n >= 40) checkVal("grant_bound", 0, 1);
  endtask

  initial begin
    int cyc;
    int held;
    int k;

    for (int i = 0; i < 4096; i++) linkMem[i] = '0;
    for (int p = 0; p < 4; p++) begin
      pkgAddr[p] = '0;
      pkgVld[p]  = 1'b0;
      pkgNum[p]  = '0;
    end
    sramEn      = 1'b1;
    iRecAddrRdy = 1'b1;
    iRst_n      = 1'b1;
    #2;
    doReset();

    // Reset state
    checkVal("rst_busy", int'(oBusy), 0);
    checkVal("rst_rec_vld", int'(oRecAddrVld), 0);
    checkVal("rst_rec_addr", int'(oRecAddr), 0);
    checkVal("rst_link_vld", int'(oLinkAddrVld), 0);
    checkVal("rst_timeout", int'(oTimeoutErr), 0);
    checkVal("rst_rdy", int'(pkgRdy), 0);

    // Single block
    recQ.delete();
    rdQ.delete();
    request(0, 70, 0);
    checkVal("single_emit_vld", int'(oRecAddrVld), 1);
    checkVal("single_emit_addr", int'(oRecAddr), 70);
    waitIdle(cyc);
    checkVal("single_busy_cycles", cyc, 1);
    checkVal("single_rec_cnt", recQ.size(), 1);
    if (recQ.size() == 1) checkVal("single_rec0", recQ[0], 70);
    checkVal("single_reads", rdQ.size(), 0);

    // Chain walk 20->21->22->23
    linkMem[20] = 12'd21;
    linkMem[21] = 12'd22;
    linkMem[22] = 12'd23;
    recQ.delete();
    rdQ.delete();
    request(1, 20, 3);
    waitIdle(cyc);
    checkVal("chain_busy_cycles", cyc, 10);
    checkVal("chain_rec_cnt", recQ.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < recQ.size()) checkVal($sformatf("chain_rec%0d", i), recQ[i], 20 + i);
    end
    checkVal("chain_rd_cnt", rdQ.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rdQ.size()) checkVal($sformatf("chain_rd%0d", i), rdQ[i], 20 + i);
    end

    // Arbitration: all four at once after reset
    doReset();
    recQ.delete();
    rdQ.delete();
    grantQ.delete();
    pkgAddr[0] = 12'd1;  pkgNum[0] = '0;
    pkgAddr[1] = 12'd20; pkgNum[1] = '0;
    pkgAddr[2] = 12'd35; pkgNum[2] = '0;
    pkgAddr[3] = 12'd70; pkgNum[3] = '0;
    for (int p = 0; p < 4; p++) pkgVld[p] = 1'b1;
    grantLoop(4);
    waitIdle(cyc);
    checkVal("arb_grant_cnt", grantQ.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grantQ.size()) checkVal($sformatf("arb_grant%0d", i), grantQ[i], i);
    end
    checkVal("arb_rec_cnt", recQ.size(), 4);
    if (recQ.size() == 4) begin
      checkVal("arb_rec0", recQ[0], 1);
      checkVal("arb_rec1", recQ[1], 20);
      checkVal("arb_rec2", recQ[2], 35);
      checkVal("arb_rec3", recQ[3], 70);
    end
    // Ports 0 and 3 again: pointer sits at 3, so port 0 wins first
    grantQ.delete();
    pkgVld[0] = 1'b1;
    pkgVld[3] = 1'b1;
    grantLoop(2);
    waitIdle(cyc);
    checkVal("arb2_grant_cnt", grantQ.size(), 2);
    if (grantQ.size() == 2) begin
      checkVal("arb2_grant0", grantQ[0], 0);
      checkVal("arb2_grant1", grantQ[1], 3);
    end

    // Backpressure on EMIT of 35 (two-block packet 35->36)
    linkMem[35] = 12'd36;
    recQ.delete();
    rdQ.delete();
    iRecAddrRdy = 1'b0;
    request(2, 35, 1);
    held = 1;
    for (int i = 0; i < 5; i++) begin
      if (!(oRecAddrVld === 1'b1 && oRecAddr === 12'd35 && oLinkAddrVld === 1'b0)) held = 0;
      tick();
    end
    checkVal("bp_hold", held, 1);
    checkVal("bp_no_read", rdQ.size(), 0);
    iRecAddrRdy = 1'b1;
    waitIdle(cyc);
    checkVal("bp_rec_cnt", recQ.size(), 2);
    if (recQ.size() == 2) begin
      checkVal("bp_rec0", recQ[0], 35);
      checkVal("bp_rec1", recQ[1], 36);
    end
    checkVal("bp_rd_cnt", rdQ.size(), 1);
    if (rdQ.size() == 1) checkVal("bp_rd0", rdQ[0], 35);

    // Reset during WAIT of a 10-block packet
    for (int i = 0; i < 9; i++) linkMem[100 + i] = AW'(101 + i);
    request(0, 100, 9);
    k = 0;
    while (!oLinkAddrVld && k < 20) begin
      tick();
      k++;
    end
    checkVal("mid_read_seen", int'(oLinkAddrVld), 1);
    tick();
    iRst_n = 1'b0;
    #1;
    checkVal("mid_rst_busy", int'(oBusy), 0);
    checkVal("mid_rst_rec_vld", int'(oRecAddrVld), 0);
    checkVal("mid_rst_rec_addr", int'(oRecAddr), 0);
    checkVal("mid_rst_link_vld", int'(oLinkAddrVld), 0);
    checkVal("mid_rst_link_addr", int'(oLinkAddr), 0);
    checkVal("mid_rst_timeout", int'(oTimeoutErr), 0);
    checkVal("mid_rst_rdy", int'(pkgRdy), 0);
    tick();
    iRst_n = 1'b1;
    tick();
    recQ.delete();
    rdQ.delete();
    request(2, 5, 0);
    waitIdle(cyc);
    checkVal("post_rst_rec_cnt", recQ.size(), 1);
    if (recQ.size() == 1) checkVal("post_rst_rec0", recQ[0], 5);
    checkVal("post_rst_reads", rdQ.size(), 0);

`ifdef PKG_DROP_TIMEOUT_EN
    // SRAM silent: timeout pulse 63 cycles after WAIT entry
    sramEn = 1'b0;
    request(1, 200, 1);
    k = 0;
    while (!oLinkAddrVld && k < 20) begin
      tick();
      k++;
    end
    tick();
    k = 0;
    while (!oTimeoutErr && k < 100) begin
      tick();
      k++;
    end
    checkVal("to_cycles", k, 63);
    checkVal("to_busy", int'(oBusy), 0);
    tick();
    checkVal("to_pulse_len", int'(oTimeoutErr), 0);
    sramEn = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
